// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
//   Groups the signals between uart_tx_feeder, the user logic that pushes
//   bytes, and the uart CSR write port.
//
//   Push side : wr_en, wr_data (in); full, empty, overflow, busy (out)
//   uart side : csr_a, csr_we, csr_di, tx_timeout (out); tx_irq (in)
//
//   slave  : view taken by the feeder itself
//   master : view taken by whatever drives the feeder (user logic / bench)
interface uart_tx_feeder_if;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        busy;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic        tx_irq;
  logic        tx_timeout;

  modport slave (
    input  wr_en, wr_data, tx_irq,
    output full, empty, overflow, busy, csr_a, csr_we, csr_di, tx_timeout
  );

  modport master (
    output wr_en, wr_data, tx_irq,
    input  full, empty, overflow, busy, csr_a, csr_we, csr_di, tx_timeout
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus transmit sequencer feeding the uart CSR write port. Bytes
//   pushed by user logic are buffered; each is handed to the uart as a single
//   csr_we strobe with csr_di = {24'b0, byte}, and the next byte is held back
//   until the uart signals completion on tx_irq.
//
// Ports
//   sys_clk  : system clock, rising edge
//   sys_rst  : asynchronous active-high reset
//   feed     : uart_tx_feeder_if.slave
//                wr_en/wr_data        push request and byte
//                full/empty           FIFO occupancy flags
//                overflow             one-cycle pulse, push refused while full
//                busy                 sequencer not idle
//                csr_a/csr_we/csr_di  uart CSR write (address fixed at 0)
//                tx_irq               uart transmit-done pulse
//                tx_timeout           one-cycle pulse when tx_irq never came
//
// Parameters
//   DEPTH_LOG2     : FIFO depth is 2**DEPTH_LOG2 bytes
//   TIMEOUT_CYCLES : WAIT cycles allowed before giving up on tx_irq
//
// Optional feature
//   UART_TX_FEEDER_TIMEOUT_EN : when defined, a watchdog abandons a byte whose
//   tx_irq has not arrived after TIMEOUT_CYCLES WAIT cycles. When undefined,
//   WAIT lasts until tx_irq and tx_timeout is tied low.
module uart_tx_feeder #(
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic             sys_clk,
  input logic             sys_rst,
  uart_tx_feeder_if.slave feed
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  // Reject configurations that cannot work before anything is built.
  if (DEPTH_LOG2 < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_config
    $error("uart_tx_feeder: DEPTH_LOG2 and TIMEOUT_CYCLES must both be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [31:0]           csr_di_q;
  logic                  overflow_q;
  logic                  full, empty, push, pop;
  logic                  csr_we, busy;
  logic                  timeout_hit;

  // count never exceeds Depth, so its top bit alone marks a full FIFO.
  assign full  = count_q[DEPTH_LOG2];
  assign empty = (count_q == '0);

  // A push is refused on the registered full flag even when a pop frees a
  // slot in the same cycle; pops only happen on the IDLE->ISSUE step.
  assign push = feed.wr_en && !full;
  assign pop  = (state_q == IDLE) && !empty;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TimerW-1:0] timer_q;
  logic              tx_timeout_q;

  // The timer holds the number of WAIT cycles already completed, so the
  // limit is hit during the last permitted WAIT cycle. A tx_irq arriving in
  // that same cycle wins and is treated as a normal completion.
  assign timeout_hit = (state_q == WAIT) && !feed.tx_irq &&
                       (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: held at zero outside WAIT, so it restarts on every
  // entry into WAIT, and counts one per WAIT cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      timer_q      <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      tx_timeout_q <= timeout_hit;
      if (state_q != WAIT) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign feed.tx_timeout = tx_timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign feed.tx_timeout = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state. tx_irq only matters in WAIT; in IDLE or ISSUE it
  // is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (feed.tx_irq || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer outputs, decoded from the registered state only.
  always_comb begin
    csr_we = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      ISSUE: begin
        csr_we = 1'b1;
        busy   = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // FIFO storage. No reset needed: entries are only read after being written.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= feed.wr_data;
    end
  end

  // FIFO pointers, occupancy, the issued-byte register and the overflow
  // flag. The pointers are exactly DEPTH_LOG2 bits, so they wrap on their
  // own. csr_di keeps the last issued byte until the next pop replaces it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      csr_di_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= feed.wr_en && full;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        csr_di_q <= {24'h000000, mem_q[rd_ptr_q]};
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign feed.full     = full;
  assign feed.empty    = empty;
  assign feed.overflow = overflow_q;
  assign feed.busy     = busy;
  assign feed.csr_a    = 14'd0;
  assign feed.csr_we   = csr_we;
  assign feed.csr_di   = csr_di_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Bench for uart_tx_feeder, built with a 4-entry FIFO and a 20-cycle
//   completion limit. A queue-based reference model predicts every output
//   each cycle; directed sequences then check latency, ordering, fill and
//   overflow, asynchronous reset, stray tx_irq and (when
//   UART_TX_FEEDER_TIMEOUT_EN is defined) the watchdog, followed by a
//   randomized run.
module tb_uart_tx_feeder;

  localparam int unsigned DepthLog2     = 2;
  localparam int unsigned Depth         = 4;
  localparam int unsigned TimeoutCycles = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  uart_tx_feeder_if feedIf ();

  uart_tx_feeder #(
    .DEPTH_LOG2    (DepthLog2),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .sys_clk(clock),
    .sys_rst(reset),
    .feed   (feedIf.slave)
  );

  int checks = 0;
  int errors = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic we, input logic [7:0] data, input logic irq);
    @(negedge clock);
    #1;
    feedIf.wr_en   = we;
    feedIf.wr_data = data;
    feedIf.tx_irq  = irq;
  endtask

  // Reference model. The FIFO is a plain queue of accepted bytes; the
  // sequencer is described only as "busy with a byte or not". An idle
  // sequencer takes the queue head at the next edge and strobes it for one
  // cycle; after that strobe it waits for tx_irq (or the watchdog limit).
  logic [7:0]  mQ[$];
  bit          mBusy    = 1'b0;
  bit          mWe      = 1'b0;
  bit          mOvf     = 1'b0;
  bit          mTo      = 1'b0;
  logic [31:0] mDi      = 32'h0;
  int          mWaitCnt = 0;
  bit          wasBusy, wasIssue, wasFull;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mQ.delete();
      mBusy    = 1'b0;
      mWe      = 1'b0;
      mOvf     = 1'b0;
      mTo      = 1'b0;
      mDi      = 32'h0;
      mWaitCnt = 0;
    end else begin
      wasBusy  = mBusy;
      wasIssue = mWe;
      wasFull  = (mQ.size() == Depth);
      mOvf     = feedIf.wr_en && wasFull;
      mTo      = 1'b0;
      mWe      = 1'b0;
      if (!wasBusy && mQ.size() != 0) begin
        mDi      = {24'h0, mQ.pop_front()};
        mWe      = 1'b1;
        mBusy    = 1'b1;
        mWaitCnt = 0;
      end else if (wasBusy && !wasIssue) begin
        if (feedIf.tx_irq) begin
          mBusy = 1'b0;
        end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        else begin
          mWaitCnt++;
          if (mWaitCnt == TimeoutCycles) begin
            mBusy = 1'b0;
            mTo   = 1'b1;
          end
        end
`endif
      end
      if (feedIf.wr_en && !wasFull) begin
        mQ.push_back(feedIf.wr_data);
      end
    end
  end

  // Every falling edge: compare all outputs with the model and log strobes.
  logic [7:0] issuedQ[$];
  int weCount  = 0;
  int ovfCount = 0;
  int toCount  = 0;

  always @(negedge clock) begin
    checkOutput("csr_we",     feedIf.csr_we,     mWe);
    checkOutput("csr_di",     feedIf.csr_di,     mDi);
    checkOutput("csr_a",      feedIf.csr_a,      32'h0);
    checkOutput("busy",       feedIf.busy,       mBusy);
    checkOutput("full",       feedIf.full,       mQ.size() == Depth);
    checkOutput("empty",      feedIf.empty,      mQ.size() == 0);
    checkOutput("overflow",   feedIf.overflow,   mOvf);
    checkOutput("tx_timeout", feedIf.tx_timeout, mTo);
    if (feedIf.csr_we === 1'b1) begin
      issuedQ.push_back(feedIf.csr_di[7:0]);
      weCount++;
    end
    if (feedIf.overflow === 1'b1) ovfCount++;
    if (feedIf.tx_timeout === 1'b1) toCount++;
  end

  // Bounded wait until the total number of csr_we strobes reaches target.
  task automatic waitForWrite(input string tag, input int target);
    int n = 0;
    while (weCount < target && n < 40) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput(tag, weCount >= target, 1'b1);
  endtask

  // Safety net so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int base;
  int baseOvf;
  int n;

  // Directed sequences followed by a randomized run.
  initial begin
    feedIf.wr_en   = 1'b0;
    feedIf.wr_data = 8'h00;
    feedIf.tx_irq  = 1'b0;

    // Reset values.
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst_csr_we", feedIf.csr_we, 1'b0);
    checkOutput("rst_csr_di", feedIf.csr_di, 32'h0);
    checkOutput("rst_empty",  feedIf.empty,  1'b1);
    checkOutput("rst_full",   feedIf.full,   1'b0);
    checkOutput("rst_busy",   feedIf.busy,   1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Single byte: strobe two edges after the push, then completion.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("a5_not_empty", feedIf.empty,  1'b0);
    checkOutput("a5_we_early",  feedIf.csr_we, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("a5_we",        feedIf.csr_we, 1'b1);
    checkOutput("a5_di",        feedIf.csr_di, 32'h0000_00A5);
    checkOutput("a5_busy",      feedIf.busy,   1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("a5_we_once",   feedIf.csr_we, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("a5_done_busy",  feedIf.busy,  1'b0);
    checkOutput("a5_done_empty", feedIf.empty, 1'b1);

    // Three bytes back-to-back, each answered ten cycles after its strobe.
    issuedQ.delete();
    base = weCount;
    for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 8'(k), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      waitForWrite("seq_wait", base + k);
      repeat (9) applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("seq_count", weCount - base, 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("seq_byte", (k < issuedQ.size()) ? issuedQ[k] : 8'hxx, 8'(k + 1));
    end

    // Fill to full with tx_irq low, then drain in order.
    issuedQ.delete();
    base    = weCount;
    baseOvf = ovfCount;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == 5) checkOutput("fill_full", feedIf.full, 1'b1);
    end
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fill_ovf_count", ovfCount - baseOvf, 32'd2);
    checkOutput("fill_still_full", feedIf.full, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (k < 4) begin
        waitForWrite("fill_wait", base + k + 2);
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
      end
    end
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fill_issued", issuedQ.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      checkOutput("fill_byte", (k < issuedQ.size()) ? issuedQ[k] : 8'hxx, 8'h10 + 8'(k));
    end
    checkOutput("fill_drained", feedIf.empty, 1'b1);

    // Asynchronous reset while waiting with three bytes queued.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("arst_pre_busy", feedIf.busy, 1'b1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_we",    feedIf.csr_we, 1'b0);
    checkOutput("arst_empty", feedIf.empty,  1'b1);
    checkOutput("arst_busy",  feedIf.busy,   1'b0);
    checkOutput("arst_di",    feedIf.csr_di, 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    base = weCount;
    repeat (10) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("arst_no_we", weCount - base, 32'd0);

    // Stray tx_irq while idle and empty.
    base = weCount;
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stray_busy",  feedIf.busy,     1'b0);
    checkOutput("stray_empty", feedIf.empty,    1'b1);
    checkOutput("stray_no_we", weCount - base,  32'd0);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Watchdog: no tx_irq after 0x55, then a normal 0x66.
    issuedQ.delete();
    base = weCount;
    applyStimulus(1'b1, 8'h55, 1'b0);
    waitForWrite("to_issue", base + 1);
    n = 0;
    begin
      int baseTo;
      baseTo = toCount;
      while (toCount == baseTo && n < 60) begin
        applyStimulus(1'b0, 8'h00, 1'b0);
        n++;
      end
    end
    checkOutput("to_latency", n, 32'd21);
    checkOutput("to_busy",    feedIf.busy, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0);
    waitForWrite("to_next", base + 2);
    checkOutput("to_next_byte", (issuedQ.size() == 2) ? issuedQ[1] : 8'hxx, 8'h66);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("to_next_done", feedIf.busy, 1'b0);
`endif

    // Randomized pushes and tx_irq pulses, checked cycle by cycle.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 4) < 2, 8'($urandom), $urandom_range(0, 5) == 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus transmit sequencer that sits directly upstream of the uart core's CSR write port.
- Accepts bytes from user logic at any rate and buffers them.
- Issues each byte to the uart as a single csr_we pulse with csr_di = {24'b0, byte}.
- Waits for the uart's tx_irq completion pulse before issuing the next byte, so no byte is overwritten mid-transmission.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16 by default).
- TIMEOUT_CYCLES, 65535, max cycles to wait for tx_irq. Used only with UART_TX_FEEDER_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request, sampled each edge.
- wr_data  in  8  byte to push.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- empty  out  1  FIFO holds 0 entries.
- overflow  out  1  one-cycle pulse when wr_en is sampled while full.
- busy  out  1  sequencer not in IDLE.
- csr_a  out  14  uart CSR address; constant 0.
- csr_we  out  1  one-cycle write strobe to the uart.
- csr_di  out  32  uart write data = {24'b0, byte}.
- tx_irq  in  1  uart transmit-done pulse.
- tx_timeout  out  1  one-cycle pulse on completion timeout; tied 0 without the macro.

Behaviour:
- Reset:
  - sys_rst asserted at any time clears read/write pointers and count (width DEPTH_LOG2+1).
  - FSM -> IDLE; csr_we=0, csr_di=0, overflow=0, tx_timeout=0, busy=0, full=0, empty=1.
  - An in-flight byte is abandoned; the uart is assumed reset by the same sys_rst.
- All outputs are registered, or decoded from registered count/state only.
- Push:
  - wr_en=1 and full=0 writes wr_data at wr_ptr; wr_ptr wraps modulo depth.
  - wr_en=1 and full=1: byte dropped, no pointer or count change, overflow=1 on the next cycle.
  - full is computed from the registered count. A push while full is rejected even if a pop occurs in the same cycle.
- Pop: only on the IDLE->ISSUE transition. rd_ptr wraps modulo depth.
- Simultaneous push and pop: both take effect, count unchanged.
- FSM states and transitions:
  - IDLE: busy=0. If empty=0: latch FIFO head into csr_di, pop, go ISSUE.
  - ISSUE: csr_we=1 for exactly this one cycle, then go WAIT.
  - WAIT: csr_we=0. On tx_irq=1 go IDLE.
- tx_irq received in IDLE or ISSUE is ignored (no state effect).
- csr_di holds the last issued byte until the next issue.
- Latency: a push into an empty FIFO with the FSM in IDLE, sampled at edge N:
  - count=1 after edge N.
  - Head is popped and ISSUE entered at edge N+1.
  - csr_we is high during the cycle following edge N+1, i.e. after 2 edges.
- Back-to-back bytes: the next csr_we occurs at least 2 cycles after the tx_irq that ended the previous byte.
- Fill to full: 2**DEPTH_LOG2 consecutive pushes into an idle, empty block are all accepted. The first byte is popped after 2 edges, freeing one slot.

Optional Feature:
- Macro: UART_TX_FEEDER_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without tx_irq: FSM -> IDLE, tx_timeout=1 for one cycle, and the byte is discarded (no retry).
  - tx_irq in the same cycle the limit is reached counts as normal completion; no timeout pulse.
- Without the macro: no counter; WAIT lasts until tx_irq; tx_timeout is constant 0.

Test Plan:
- Reset, then push 0xA5 once. Required: csr_we high for one cycle 2 edges later, csr_di=0x000000A5, csr_a=0, busy=1. Pulse tx_irq -> busy=0 and empty=1 one cycle later.
- Push 0x01..0x03 back-to-back; answer each csr_we with tx_irq 10 cycles later. Required: exactly three csr_we pulses carrying 0x01, 0x02, 0x03 in order. No csr_we while in WAIT.
- With DEPTH_LOG2=2 and tx_irq held 0, push 0x10..0x16 (7 bytes). Required:
  - First byte is popped after 2 edges; the next 4 are accepted; full=1 after the 5th push.
  - Pushes 6 and 7 are rejected, each with a one-cycle overflow pulse.
  - Pulsing tx_irq then drains 0x11..0x14 in order.
- Assert sys_rst asynchronously (between edges) while in WAIT with 3 bytes queued. Required: csr_we=0, empty=1, busy=0 immediately. After release, no csr_we occurs until a new push.
- Pulse tx_irq while IDLE and empty. Required: no state change, no csr_we.
- With UART_TX_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=20, push 0x55 and never pulse tx_irq. Required: tx_timeout pulses after 20 WAIT cycles and busy returns to 0. A subsequent push of 0x66 is issued normally.
